serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Bit-serial adder/subtractor that runs one operation frame per reset release.
- Operand bits arrive LSB-first on m0 (A) and m1 (B); m2 selects add or subtract; cin is the initial carry.
- Result leaves on dout: WIDTH sum bits LSB-first, then the final carry-out.
- Used as a lab-level datapath top fed by switches/bench.

Parameters:
- WIDTH, 8: number of operand bits per frame (legal 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- m0  input  1  serial operand A bit, LSB first, sampled during RUN.
- m1  input  1  serial operand B bit, LSB first, sampled during RUN.
- m2  input  1  operation select: 1 = add (A+B+c), 0 = subtract (A+~B+c).
- cin  input  1  initial carry (use 1 for two's-complement subtract), sampled in LOAD.
- dout  output  1  registered serial result.

Behaviour:
- Reset low (async): state=LOAD, carry=0, bit count=0, dout=0. Held while reset is low.
- FSM states: LOAD, RUN, DONE, IDLE.
- LOAD: on the first rising edge with reset high, carry<=cin, count<=0, state<=RUN; dout stays 0.
- RUN, each edge:
  - b_eff = m1 ^ ~m2; s = m0 ^ b_eff ^ carry; cout = majority(m0, b_eff, carry).
  - dout<=s, carry<=cout, count<=count+1.
  - After WIDTH RUN edges, state<=DONE.
- DONE, one edge: dout<=carry (final carry-out / no-borrow flag), state<=IDLE.
- IDLE: dout<=0 each edge; stays in IDLE until the next reset assertion. Inputs are ignored.
- Latency:
  - Sum bit k (k=0..WIDTH-1) is on dout after edge k+2 following reset release.
  - Carry-out is on dout after edge WIDTH+2.
  - Frame length is WIDTH+2 cycles.
- m2 and cin are sampled every RUN cycle and in LOAD respectively. Changing m2 mid-frame takes effect on that bit only; no error is flagged.
- Reset mid-frame: immediate abort to LOAD with dout=0; no partial result is retained.
- Count width is clog2(WIDTH+1); no wrap, because the FSM leaves RUN exactly at count==WIDTH-1.
- All registers are clocked by clk only; no combinational path from inputs to dout.

Optional Feature:
- STICKY_CARRY_EN defined: IDLE holds dout at the final carry-out value instead of 0, until the next reset.
- Undefined: IDLE drives dout=0 as above.
- No other behaviour changes.

Decomposition:
- Package serial_addsub_pkg:
  - state enum (LOAD, RUN, DONE, IDLE).
  - default WIDTH constant.
  - function for the count width.
- One sub-module serial_fa_cell: combinational full adder (a, b, c -> s, cout) with the b-invert controlled by the m2 select.
- FSM, counter and carry/dout registers stay in serial_addsub_unit.

Test Plan:
- Add, WIDTH=8, m0=1 m1=0 m2=1 cin=1 held, reset pulse -> dout 0 x8 then 1 (0xFF+0x00+1=0x100), then 0 in IDLE.
- Add, m0=1 m1=0 m2=1 cin=0 -> dout 1 x8 then 0 (0xFF).
- Add, m0=1 m1=1 m2=1 cin=1 -> dout 1 x8 then 1 (0x1FF).
- Add, m0=0 m1=1 m2=1 cin=1 -> dout 0 x8 then 1 (0x100).
- Subtract, m0=1 m1=1 m2=0 cin=1 (0xFF-0xFF) -> dout 0 x8 then 1 (no borrow). Then reset asserted at RUN bit 3 -> dout drops to 0 asynchronously; a fresh frame starts after release.
- Variable operands, A=0x35 B=0x1C (LSB-first on m0/m1), m2=1 cin=0 -> sum 0x51 bits 1,0,0,0,1,0,1,0 then carry 0. With STICKY_CARRY_EN and the 0x100 case, dout stays 1 in IDLE.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The STICKY_CARRY_EN build option is handled in serial_addsub_unit.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        IDLE = 2'd3
    } state_t;

    // Bit counter must be able to hold WIDTH itself after the last RUN edge.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder cell with optional operand-B inversion for subtract.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic add_sel,
    output logic s,
    output logic cout
);

    logic b_eff;

    // add_sel=1 passes B; add_sel=0 inverts B so A+~B+c forms A-B with c=1.
    assign b_eff = b ^ ~add_sel;
    assign s     = a ^ b_eff ^ c;
    assign cout  = (a & b_eff) | (a & c) | (b_eff & c);

endmodule

// File: rtl/serial_addsub_unit.sv
// One-frame-per-reset bit-serial adder/subtractor: WIDTH sum bits LSB-first, then carry-out.
// Build option STICKY_CARRY_EN: IDLE holds dout at the final carry-out instead of 0.
//
//   state | meaning
//   LOAD  | first edge after reset release: latch cin, clear bit count
//   RUN   | one operand bit per edge, sum bit to dout
//   DONE  | present final carry-out on dout
//   IDLE  | frame finished, inputs ignored until next reset
module serial_addsub_unit
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic m0,
    input  logic m1,
    input  logic m2,
    input  logic cin,
    output logic dout
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   count_q, count_d;
    logic            dout_q,  dout_d;

    logic            fa_s;
    logic            fa_cout;

    serial_fa_cell u_fa (
        .a       (m0),
        .b       (m1),
        .c       (carry_q),
        .add_sel (m2),
        .s       (fa_s),
        .cout    (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        count_d = count_q;
        dout_d  = 1'b0;
        case (state_q)
            LOAD: begin
                carry_d = cin;
                count_d = '0;
                state_d = RUN;
            end
            RUN: begin
                dout_d  = fa_s;
                carry_d = fa_cout;
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dout_d  = carry_q;
                state_d = IDLE;
            end
            IDLE: begin
`ifdef STICKY_CARRY_EN
                dout_d = dout_q;
`else
                dout_d = 1'b0;
`endif
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            carry_q <= 1'b0;
            count_q <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed self-checking bench for serial_addsub_unit (WIDTH=8).
module tb_serial_addsub_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic m0 = 1'b0;
    logic m1 = 1'b0;
    logic m2 = 1'b1;
    logic cin = 1'b0;
    logic dout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .cin   (cin),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Full frame: reset pulse, LOAD, 8 RUN bits, DONE, then two IDLE cycles.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic op, input logic ci, input logic [8:0] exp);
        logic idle_exp;
        @(negedge clk);
        reset = 1'b0;
        m0 = a[0];
        m1 = b[0];
        m2 = op;
        cin = ci;
        #1;
        check({tag, "_rst"}, dout, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_load"}, dout, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("%s_bit%0d", tag, k), dout, exp[k]);
            if (k < 7) begin
                m0 = a[k+1];
                m1 = b[k+1];
            end
        end
        @(negedge clk);
        check({tag, "_cout"}, dout, exp[8]);
        m0 = ~m0;
        m1 = ~m1;
        cin = ~cin;
`ifdef STICKY_CARRY_EN
        idle_exp = exp[8];
`else
        idle_exp = 1'b0;
`endif
        @(negedge clk);
        check({tag, "_idle0"}, dout, idle_exp);
        @(negedge clk);
        check({tag, "_idle1"}, dout, idle_exp);
    endtask

    initial begin
        run_frame("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 1'b1, 9'h100);
        run_frame("add_ff_00_c0", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h0FF);
        run_frame("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
        run_frame("add_00_ff_c1", 8'h00, 8'hFF, 1'b1, 1'b1, 9'h100);
        run_frame("sub_ff_ff",    8'hFF, 8'hFF, 1'b0, 1'b1, 9'h100);
        run_frame("sub_05_07",    8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE);

        // Abort mid-frame: 0xFF+0x00 with cin=0 makes every sum bit 1.
        @(negedge clk);
        reset = 1'b0;
        m0 = 1'b1;
        m1 = 1'b0;
        m2 = 1'b1;
        cin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_bit%0d", k), dout, 1'b1);
        end
        @(posedge clk);
        #2;
        check("abort_bit4", dout, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_async", dout, 1'b0);
        @(negedge clk);
        check("abort_held", dout, 1'b0);

        run_frame("add_35_1c", 8'h35, 8'h1C, 1'b1, 1'b0, 9'h051);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
